// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        ZERO  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    // Ceiling log2, used to size the iteration counter (n >= 2).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus of the divider.
interface seq_restoring_divider_if #(
    parameter int unsigned WIDTH = div_pkg::DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/cla_subtractor.sv
// N-bit carry-lookahead subtractor: diff = a - b computed as a + ~b + 1.
module cla_subtractor #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = a & ~b;
    assign p = a ^ ~b;

    // Each carry is expanded from g/p and the carry-in, so no carry depends on another.
    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | pp;
        end
    end

    assign diff       = p ^ c[N-1:0];
    assign borrow_out = ~c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [RW-1:0]    rem_q;
    logic [CW-1:0]    cnt_q;
    logic             dbz_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic [RW-1:0]    r_shift_c;
    logic [RW-1:0]    trial_c;
    logic             borrow_c;
    logic             last_c;

    // Shift the next dividend bit into the partial remainder; its top bit is always 0 here.
    assign r_shift_c = RW'({rem_q, dvd_q[WIDTH-1]});
    assign last_c    = (cnt_q == CW'(WIDTH - 1));

    cla_subtractor #(.N(RW)) u_sub (
        .a          (r_shift_c),
        .b          ({1'b0, dvs_q}),
        .diff       (trial_c),
        .borrow_out (borrow_c)
    );

`ifdef DIV_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg(x) : x;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = (bus.divisor == '0) ? ZERO : CALC;
            end
            CALC: begin
`ifdef DIV_SIGNED_EN
                if (last_c) state_d = FIXUP;
`else
                if (last_c) state_d = DONE;
`endif
            end
            ZERO:    state_d = DONE;
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Working registers: capture, iterate, and finalise the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
`ifdef DIV_SIGNED_EN
                        dvd_q     <= (bus.divisor == '0) ? bus.dividend : mag(bus.dividend);
                        dvs_q     <= mag(bus.divisor);
                        neg_quo_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_rem_q <= bus.dividend[WIDTH-1];
`else
                        dvd_q <= bus.dividend;
                        dvs_q <= bus.divisor;
`endif
                        quo_q <= '0;
                        rem_q <= '0;
                        cnt_q <= '0;
                        dbz_q <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q <= borrow_c ? r_shift_c : trial_c;
                    quo_q <= {quo_q[WIDTH-2:0], ~borrow_c};
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= last_c ? '0 : cnt_q + CW'(1);
                end
                ZERO: begin
                    quo_q <= '1;
                    rem_q <= RW'(dvd_q);
                    dbz_q <= 1'b1;
                end
`ifdef DIV_SIGNED_EN
                // Truncating division: quotient sign from XOR, remainder follows the dividend.
                FIXUP: begin
                    if (neg_quo_q) quo_q <= neg(quo_q);
                    if (neg_rem_q) rem_q <= RW'(neg(rem_q[WIDTH-1:0]));
                end
`endif
                default: ;
            endcase
        end
    end

    // Registered handshake and result outputs; results only move when leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            busy_q <= (state_d == CALC) || (state_d == ZERO) || (state_d == FIXUP);
            done_q <= (state_q == DONE);
            if (state_q == DONE) begin
                quotient_q    <= quo_q;
                remainder_q   <= rem_q[WIDTH-1:0];
                div_by_zero_q <= dbz_q;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider at WIDTH=8.
module tb_seq_restoring_divider;

    localparam int unsigned W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif
    localparam int ZLAT   = 2;
    localparam int BUDGET = 40;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_dbz;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one divide, optionally poke a new start mid-flight, wait for done and check results.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edbz, input int lat, input int intrude);
        int n;
        bit seen;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'hAA;
        bus.divisor  = 8'h55;
        chk("busy_after_accept", 32'(bus.busy), 32'(1));
        chk("done_after_accept", 32'(bus.done), 32'(0));
        n    = 0;
        seen = 1'b0;
        while (!seen && n < BUDGET) begin
            if (n == intrude) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 8'd5;
            end
            tick();
            n++;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                chk("busy_window", 32'(bus.busy), 32'(n <= lat - 2));
                chk("hold_quotient", 32'(bus.quotient), 32'(last_q));
                chk("hold_remainder", 32'(bus.remainder), 32'(last_r));
                chk("hold_dbz", 32'(bus.div_by_zero), 32'(last_dbz));
            end
        end
        chk("latency", 32'(n), 32'(lat));
        chk("quotient", 32'(bus.quotient), 32'(eq));
        chk("remainder", 32'(bus.remainder), 32'(er));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(edbz));
        chk("busy_at_done", 32'(bus.busy), 32'(0));
        last_q   = eq;
        last_r   = er;
        last_dbz = edbz;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_done"}, 32'(bus.done), 32'(0));
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'(0));
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'(0));
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        last_q       = '0;
        last_r       = '0;
        last_dbz     = 1'b0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // 100 / 7 = 14 r 2
        run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, -1);

        // Back-to-back: 255/1 then 3/200 started on the IDLE cycle after done
        run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT, -1);
        run_div(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, LAT, -1);

        // Divide by zero, then a normal divide clears the flag
        run_div(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, ZLAT, -1);
        run_div(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, LAT, -1);

        // dividend = 0
        run_div(8'd0, 8'd13, 8'd0, 8'd0, 1'b0, LAT, -1);

        // Start with 50/5 during cycle 4 of 100/7 must be ignored
        run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, 4);
        tick();
        chk("no_retrigger_busy", 32'(bus.busy), 32'(0));
        chk("no_retrigger_done", 32'(bus.done), 32'(0));

        // Reset during cycle 5 of a divide aborts it
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        last_q   = '0;
        last_r   = '0;
        last_dbz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 32'(0));
        end
        rst_n = 1'b1;
        tick();
        chk("abort_released_done", 32'(bus.done), 32'(0));

        run_div(8'd81, 8'd9, 8'd9, 8'd0, 1'b0, LAT, -1);

`ifdef DIV_SIGNED_EN
        // -100 / 7 = -14 r -2 ; -128 / -1 = -128 r 0
        run_div(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, LAT, -1);
        run_div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative radix-2 restoring divider; the inverse operation to the team's multiplier datapath.
- Produces quotient and remainder of two WIDTH-bit unsigned operands, one quotient bit per clock.
- Trial subtraction is performed by a carry-lookahead subtractor sub-module.
- Sits beside the Wallace-tree multipliers as the arithmetic unit's divide path, driven by a start/done handshake.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (>= 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  numerator, captured with start
- divisor  input  WIDTH  denominator, captured with start
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  result, held until next accepted start
- remainder  output  WIDTH  result, held until next accepted start
- div_by_zero  output  1  set with done when divisor==0, held with results

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, div_by_zero, quotient, remainder all 0.
  - Internal iteration counter 0.
  - Reset mid-operation aborts the divide; no done is produced.
- States:
  - IDLE: start=1 captures operands. Next state is CALC, or ZERO if divisor==0. busy rises next cycle.
  - CALC: per cycle, partial remainder R (WIDTH+1 bits) = {R[WIDTH-1:0], next dividend MSB}.
    - Trial D = R - {0,divisor} via the CLA subtractor.
    - If the borrow-out is 0: R=D and the quotient bit is 1.
    - Otherwise R is kept and the quotient bit is 0.
    - Counter runs 0..WIDTH-1. At WIDTH-1, go to DONE.
  - ZERO: quotient = all ones, remainder = dividend, div_by_zero=1; go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, outputs updated; return to IDLE.
- Latency:
  - Start accepted at edge 0.
  - Normal divide: done high after edge WIDTH+1 (9 cycles at WIDTH=8).
  - Divide by zero: done high after edge 2.
- Handshake:
  - start is ignored while busy=1 or in DONE.
  - start held high continuously re-triggers on the first IDLE cycle after DONE.
- Output stability:
  - quotient, remainder and div_by_zero change only on the DONE cycle.
  - They are stable during a following computation.
  - div_by_zero clears on the next non-zero-divisor DONE.
- Width rules: R needs WIDTH+1 bits so the borrow is visible. Remainder output is R[WIDTH-1:0], always < divisor.
- Boundaries:
  - dividend < divisor gives quotient 0, remainder = dividend.
  - divisor=1 gives quotient = dividend.
  - dividend=0 gives 0/0 with no special path.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are divided.
  - A FIXUP state is inserted between CALC and DONE, adding one cycle of latency (WIDTH+2).
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign (truncating division).
  - Most-negative / -1 yields quotient = most-negative, remainder 0, no flag.
  - Divide by zero behaves as unsigned.
- Undefined: unsigned only, no FIXUP state, latency WIDTH+1.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, ZERO, FIXUP, DONE}.
  - DIV_WIDTH_DEFAULT=8.
  - Counter-width function clog2(WIDTH).
- Sub-module cla_subtractor:
  - Parameterised WIDTH+1-bit carry-lookahead A - B, computed as A + ~B + 1.
  - Outputs difference and borrow_out.
  - Built from generate/propagate lookahead, consistent with the existing CLA adders.

Test Plan (WIDTH=8):
- dividend=100, divisor=7, start for one cycle → done after edge 9; quotient=14, remainder=2, div_by_zero=0; busy high on cycles 1–8.
- 255/1, then 3/200 back-to-back (second start on the IDLE cycle after done) → 255 r0, then 0 r3; no lost or duplicate done.
- 5/0 → done after edge 2; quotient=0xFF, remainder=5, div_by_zero=1; a following 9/3 gives 3 r0 with div_by_zero=0.
- start=1 with new operands (50/5) during cycle 4 of 100/7 → ignored; result 14 r2; outputs unchanged until that DONE.
- rst_n low at cycle 5 of a divide → all outputs 0 immediately, no done pulse; a fresh 81/9 afterwards gives 9 r0.
- DIV_SIGNED_EN: -100/7 → quotient=0xF2 (-14), remainder=0xFE (-2), done after edge 10; -128/-1 → 0x80 r0.
